framebuffer_writer: RTL

// - Consumer end of the per-pixel colour stream. Takes 32-bit RGBA pixels (32'hRRGGBBAA) on pixel_clk, one per accepted beat.
// - Buffers pixels in a small FIFO and writes each to a linear framebuffer in memory through a valid/ready write port.
// - Addresses are raster order: BASE_ADDR + 4*(y*H_RES + x).
// - Sits between the scene pixel output and the memory/display subsystem. Signals end of frame to the frame sequencer.

---
 rtl/framebuffer_writer_pkg.sv | 15 +
 rtl/framebuffer_writer_if.sv | 34 +++
 rtl/framebuffer_writer_pixel_fifo.sv | 62 ++++++
 rtl/framebuffer_writer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/framebuffer_writer_pkg.sv
// Shared graphics types for the pixel path.
// Pixel word, writer FSM states and bytes per pixel.
package graphics;

   typedef logic [31:0] pixel_t;

   typedef enum logic [1:0] {
      FW_IDLE,
      FW_ACTIVE,
      FW_DRAIN
   } fb_state_t;

   localparam int PIXEL_BYTES = 4;

endpackage

// File: rtl/framebuffer_writer_if.sv
// Pixel stream in + memory write port out.
// slave: writer side; master: producer/memory side.
interface framebuffer_writer_if;
   import graphics::*;

   logic        pixel_valid;
   pixel_t      pixel_data;
   logic        pixel_ready;
   logic        mem_valid;
   logic [31:0] mem_addr;
   pixel_t      mem_wdata;
   logic        mem_ready;

   modport slave (
      input  pixel_valid,
      input  pixel_data,
      output pixel_ready,
      output mem_valid,
      output mem_addr,
      output mem_wdata,
      input  mem_ready
   );

   modport master (
      output pixel_valid,
      output pixel_data,
      input  pixel_ready,
      input  mem_valid,
      input  mem_addr,
      input  mem_wdata,
      output mem_ready
   );

endinterface

// File: rtl/framebuffer_writer_pixel_fifo.sv
// Synchronous pixel FIFO with registered full/empty flags.
// Ports: clk, rst_n, push, pop, din, dout (head), full, empty.
module pixel_fifo
   import graphics::*;
#(
   parameter int DEPTH = 16
)(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  logic   pop,
   input  pixel_t din,
   output pixel_t dout,
   output logic   full,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);

   pixel_t         r_mem [DEPTH];
   logic [AW:0]    r_wr;
   logic [AW:0]    r_rd;
   logic           r_full;
   logic           r_empty;
   logic           w_push;
   logic           w_pop;
   logic [AW:0]    w_wr_nxt;
   logic [AW:0]    w_rd_nxt;

   // Guard against over/underflow regardless of the caller.
   assign w_push   = push && !r_full;
   assign w_pop    = pop && !r_empty;
   assign w_wr_nxt = r_wr + (AW+1)'(w_push);
   assign w_rd_nxt = r_rd + (AW+1)'(w_pop);

   assign dout  = r_mem[r_rd[AW-1:0]];
   assign full  = r_full;
   assign empty = r_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         r_wr    <= w_wr_nxt;
         r_rd    <= w_rd_nxt;
         r_empty <= (w_wr_nxt == w_rd_nxt);
         // Same index, opposite wrap bit: one full lap ahead.
         r_full  <= (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                    (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
      end
   end

endmodule

// File: rtl/framebuffer_writer.sv
// Writes one frame of RGBA pixels to a linear raster framebuffer.
// Ports: pixel_clk, rst_n, frame_start, bus (stream + mem), frame_done, frame_err.
module framebuffer_writer
   import graphics::*;
#(
   parameter int unsigned H_RES      = 640,
   parameter int unsigned V_RES      = 480,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h0
)(
   input  logic                pixel_clk,
   input  logic                rst_n,
   input  logic                frame_start,
   framebuffer_writer_if.slave bus,
   output logic                frame_done,
   output logic                frame_err
);

   localparam int unsigned NPIX = H_RES * V_RES;
   localparam int CW = $clog2(NPIX + 1);
   localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

   fb_state_t      r_state;
   logic [CW-1:0]  r_in_count;
   logic [XW-1:0]  r_x;
   logic [YW-1:0]  r_y;
   logic [31:0]    r_addr;
   logic           r_done;
   logic           r_err;

   logic           w_full;
   logic           w_empty;
   logic           w_push;
   logic           w_pop;
   logic           w_last_x;
   logic           w_last_y;
   logic           w_last_wr;
   pixel_t         w_head;

   // Ready uses only the registered full flag.
   assign bus.pixel_ready = (r_state == FW_ACTIVE) && !w_full;
   assign w_push = bus.pixel_valid && bus.pixel_ready;
   assign w_pop  = !w_empty && bus.mem_ready;

   // Outputs read zero whenever no write is offered.
   assign bus.mem_valid = !w_empty;
   assign bus.mem_addr  = w_empty ? '0 : r_addr;
   assign bus.mem_wdata = w_empty ? '0 : w_head;

   assign w_last_x  = (r_x == XW'(H_RES - 1));
   assign w_last_y  = (r_y == YW'(V_RES - 1));
   assign w_last_wr = w_pop && w_last_x && w_last_y;

   assign frame_done = r_done;
   assign frame_err  = r_err;

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (pixel_clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .din   (bus.pixel_data),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= FW_IDLE;
         r_in_count <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_addr     <= BASE_ADDR;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= 1'b0;

         // Raster walk: step the address on every write handshake.
         if (w_pop) begin
            if (w_last_x) begin
               r_x <= '0;
               if (w_last_y) begin
                  r_y    <= '0;
                  r_addr <= BASE_ADDR;
               end else begin
                  r_y    <= r_y + 1'b1;
                  r_addr <= r_addr + 32'(PIXEL_BYTES);
               end
            end else begin
               r_x    <= r_x + 1'b1;
               r_addr <= r_addr + 32'(PIXEL_BYTES);
            end
         end

         unique case (r_state)
            FW_IDLE: begin
               if (frame_start) begin
                  // A start landing on the done pulse is refused.
                  if (r_done) begin
                     r_err <= 1'b1;
                  end else begin
                     r_state    <= FW_ACTIVE;
                     r_in_count <= '0;
                     r_x        <= '0;
                     r_y        <= '0;
                     r_addr     <= BASE_ADDR;
                  end
               end
            end
            FW_ACTIVE: begin
               if (frame_start) begin
                  r_err <= 1'b1;
               end
               if (w_push) begin
                  r_in_count <= r_in_count + 1'b1;
                  if (r_in_count == CW'(NPIX - 1)) begin
                     r_state <= FW_DRAIN;
                  end
               end
            end
            FW_DRAIN: begin
               if (frame_start) begin
                  r_err <= 1'b1;
               end
               // Last raster position popping means FIFO drains now.
               if (w_last_wr) begin
                  r_done  <= 1'b1;
                  r_state <= FW_IDLE;
               end
            end
            default: begin
               r_state <= FW_IDLE;
            end
         endcase
      end
   end

endmodule
